// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
// Holds the run-state enum, the digit moduli and the BCD digit type.
// No logic lives here.
package stopwatch_pkg;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } sw_state_t;

   localparam int MOD_DEC = 10;
   localparam int MOD_SEX = 6;

   typedef logic [3:0] bcd_t;
endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit counting 0..MOD-1; at_max flags the top value for the carry chain.
// Latency: inc or clr in cycle N is visible on q after edge N+1.
// Backpressure: none; clr has priority over inc.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter int MOD = MOD_DEC
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] q,
   output logic       at_max
);

   bcd_t q_d;
   bcd_t q_q;

   assign at_max = (q_q == 4'(MOD - 1));
   assign q      = q_q;

   // Next digit value: clear wins, otherwise wrap to 0 from the top value on inc.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc) begin
         q_d = at_max ? 4'd0 : q_q + 4'd1;
      end
   end

   // Digit register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS.cc stopwatch with start/stop, clear and lap-freeze, driving six BCD digit outputs.
// Latency: a button event in cycle N acts at edge N+1; a tick in cycle N updates the count at edge N+1.
// Backpressure: none; a clear event overrides every other event in the same cycle.
module bcd_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] d5,
   output logic [3:0] d4,
   output logic [3:0] d3,
   output logic [3:0] d2,
   output logic [3:0] d1,
   output logic [3:0] d0,
   output logic       running,
   output logic       frozen,
   output logic       wrap
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

   if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
      $error("bcd_stopwatch: CLK_HZ/TICK_HZ must be an integer >= 2");
   end

   sw_state_t     state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          start_stop_q, clear_q, lap_prev_q;
   logic          running_q, running_d;
   logic          frozen_q, frozen_d;
   logic          wrap_q, wrap_d;
   logic [23:0]   lap_cnt_q, lap_cnt_d;

   logic          ev_clr, ev_ss, ev_lap, tick;
   logic [5:0]    dig_inc, dig_max;
   logic [3:0]    live [6];
   logic [23:0]   live_cnt;

   assign ev_clr   = clear & ~clear_q;
   assign ev_ss    = ~ev_clr & start_stop & ~start_stop_q;
   assign ev_lap   = ~ev_clr & lap & ~lap_prev_q & (state_q != S_IDLE);
   assign tick     = (state_q == S_RUN) && (presc_q == PW'(DIV - 1));
   assign live_cnt = {live[5], live[4], live[3], live[2], live[1], live[0]};

   // Carry chain: a digit advances on a tick only when every lower digit sits at its maximum.
   always_comb begin
      dig_inc[0] = tick;
      for (int k = 1; k < 6; k++) begin
         dig_inc[k] = dig_inc[k-1] & dig_max[k-1];
      end
   end

   bcd_digit #(.MOD(MOD_DEC)) u_d0 (.clk(clk), .resetn(resetn), .clr(ev_clr), .inc(dig_inc[0]), .q(live[0]), .at_max(dig_max[0]));
   bcd_digit #(.MOD(MOD_DEC)) u_d1 (.clk(clk), .resetn(resetn), .clr(ev_clr), .inc(dig_inc[1]), .q(live[1]), .at_max(dig_max[1]));
   bcd_digit #(.MOD(MOD_DEC)) u_d2 (.clk(clk), .resetn(resetn), .clr(ev_clr), .inc(dig_inc[2]), .q(live[2]), .at_max(dig_max[2]));
   bcd_digit #(.MOD(MOD_SEX)) u_d3 (.clk(clk), .resetn(resetn), .clr(ev_clr), .inc(dig_inc[3]), .q(live[3]), .at_max(dig_max[3]));
   bcd_digit #(.MOD(MOD_DEC)) u_d4 (.clk(clk), .resetn(resetn), .clr(ev_clr), .inc(dig_inc[4]), .q(live[4]), .at_max(dig_max[4]));
   bcd_digit #(.MOD(MOD_SEX)) u_d5 (.clk(clk), .resetn(resetn), .clr(ev_clr), .inc(dig_inc[5]), .q(live[5]), .at_max(dig_max[5]));

   // Next-state logic for the run FSM, prescaler, lap freeze and rollover pulse.
   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      frozen_d  = frozen_q;
      lap_cnt_d = lap_cnt_q;
      wrap_d    = tick & (&dig_max) & ~ev_clr;

      if (ev_clr) begin
         state_d   = S_IDLE;
         presc_d   = '0;
         frozen_d  = 1'b0;
         lap_cnt_d = '0;
      end else begin
         if (ev_ss) begin
            case (state_q)
               S_IDLE:  state_d = S_RUN;
               S_RUN:   state_d = S_PAUSE;
               S_PAUSE: state_d = S_RUN;
               default: state_d = S_IDLE;
            endcase
         end
         // The prescaler holds outside RUN so a resume finishes the partial period.
         if (state_q == S_RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
         end
         if (ev_lap) begin
            frozen_d = ~frozen_q;
            // Capture the pre-increment count on the freezing edge.
            if (!frozen_q) begin
               lap_cnt_d = live_cnt;
            end
         end
      end
      running_d = (state_d == S_RUN);
   end

   // All control state and registered outputs; reset wins over any pending tick or event.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         presc_q      <= '0;
         start_stop_q <= 1'b1;
         clear_q      <= 1'b1;
         lap_prev_q   <= 1'b1;
         running_q    <= 1'b0;
         frozen_q     <= 1'b0;
         wrap_q       <= 1'b0;
         lap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         start_stop_q <= start_stop;
         clear_q      <= clear;
         lap_prev_q   <= lap;
         running_q    <= running_d;
         frozen_q     <= frozen_d;
         wrap_q       <= wrap_d;
         lap_cnt_q    <= lap_cnt_d;
      end
   end

   assign {d5, d4, d3, d2, d1, d0} = frozen_q ? lap_cnt_q : live_cnt;
   assign running = running_q;
   assign frozen  = frozen_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch at CLK_HZ=100, TICK_HZ=10 (ten cycles per hundredth).
// Inputs change and outputs are sampled on the falling edge.
// Digits are compared as a 24-bit BCD word {d5..d0}.
module tb_bcd_stopwatch;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic       lap = 1'b0;
   logic [3:0] d5, d4, d3, d2, d1, d0;
   logic       running, frozen, wrap;

   int checks = 0;
   int failures = 0;

   logic [23:0] disp;
   assign disp = {d5, d4, d3, d2, d1, d0};

   bcd_stopwatch #(.CLK_HZ(100), .TICK_HZ(10)) dut (
      .clk(clk), .resetn(resetn), .start_stop(start_stop), .clear(clear), .lap(lap),
      .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
      .running(running), .frozen(frozen), .wrap(wrap)
   );

   always #5 clk = ~clk;

   // Digits must never leave their legal ranges.
   always @(negedge clk) begin
      if (resetn && (d0 > 9 || d1 > 9 || d2 > 9 || d3 > 5 || d4 > 9 || d5 > 5)) begin
         failures++;
         $display("FAIL digit_range got %h", disp);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      step(1);
   endtask

   // Leaves the bench at the falling edge just after running rises.
   task automatic press_start();
      start_stop = 1'b1;
      step(1);
      start_stop = 1'b0;
   endtask

   task automatic force_max();
      force dut.u_d0.q_q = 4'd9;
      force dut.u_d1.q_q = 4'd9;
      force dut.u_d2.q_q = 4'd9;
      force dut.u_d3.q_q = 4'd5;
      force dut.u_d4.q_q = 4'd9;
      force dut.u_d5.q_q = 4'd5;
      force dut.presc_q = 4'd9;
      #1;
      release dut.u_d0.q_q;
      release dut.u_d1.q_q;
      release dut.u_d2.q_q;
      release dut.u_d3.q_q;
      release dut.u_d4.q_q;
      release dut.u_d5.q_q;
      release dut.presc_q;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      start_stop = 1'b1;
      step(3);
      resetn = 1'b1;
      step(5);
      checks++; if (disp !== 24'h000000) begin failures++; $display("FAIL reset_digits got %h want 000000", disp); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got %b want 0", running); end
      checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL reset_frozen got %b want 0", frozen); end
      checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got %b want 0", wrap); end
      start_stop = 1'b0;
      step(1);
   endtask

   task automatic test_start_count();
      press_start();
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running got %b want 1", running); end
      step(9);
      checks++; if (disp !== 24'h000000) begin failures++; $display("FAIL start_before_first got %h want 000000", disp); end
      step(1);
      checks++; if (disp !== 24'h000001) begin failures++; $display("FAIL start_first_inc got %h want 000001", disp); end
      step(240);
      checks++; if (disp !== 24'h000025) begin failures++; $display("FAIL start_250 got %h want 000025", disp); end
   endtask

   task automatic test_pause_resume();
      do_clear();
      checks++; if (disp !== 24'h000000 || running !== 1'b0) begin failures++; $display("FAIL clear_idle got %h run=%b want 000000 run=0", disp, running); end
      press_start();
      step(34);
      checks++; if (disp !== 24'h000003) begin failures++; $display("FAIL pause_at35 got %h want 000003", disp); end
      start_stop = 1'b1;
      step(1);
      start_stop = 1'b0;
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL pause_running got %b want 0", running); end
      step(99);
      checks++; if (disp !== 24'h000003) begin failures++; $display("FAIL pause_hold got %h want 000003", disp); end
      start_stop = 1'b1;
      step(1);
      start_stop = 1'b0;
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL resume_running got %b want 1", running); end
      step(65);
      checks++; if (disp !== 24'h000010) begin failures++; $display("FAIL resume_65 got %h want 000010", disp); end
   endtask

   task automatic test_lap();
      do_clear();
      press_start();
      step(120);
      checks++; if (disp !== 24'h000012) begin failures++; $display("FAIL lap_pre got %h want 000012", disp); end
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      checks++; if (frozen !== 1'b1) begin failures++; $display("FAIL lap_frozen got %b want 1", frozen); end
      step(49);
      checks++; if (disp !== 24'h000012) begin failures++; $display("FAIL lap_hold got %h want 000012", disp); end
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL lap_unfreeze got %b want 0", frozen); end
      checks++; if (disp !== 24'h000017) begin failures++; $display("FAIL lap_live got %h want 000017", disp); end
   endtask

   task automatic test_lap_idle();
      do_clear();
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      step(1);
      checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL lap_idle got %b want 0", frozen); end
   endtask

   task automatic test_wrap();
      do_clear();
      press_start();
      force_max();
      step(1);
      checks++; if (disp !== 24'h000000) begin failures++; $display("FAIL wrap_digits got %h want 000000", disp); end
      checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL wrap_pulse got %b want 1", wrap); end
      step(1);
      checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL wrap_one_cycle got %b want 0", wrap); end
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL wrap_running got %b want 1", running); end
   endtask

   task automatic test_clear_collisions();
      do_clear();
      press_start();
      step(5);
      clear = 1'b1;
      start_stop = 1'b1;
      step(1);
      checks++; if (running !== 1'b0 || disp !== 24'h000000) begin failures++; $display("FAIL clr_ss got %h run=%b want 000000 run=0", disp, running); end
      clear = 1'b0;
      start_stop = 1'b0;
      step(3);
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL clr_ss_idle got %b want 0", running); end
      press_start();
      force_max();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      checks++; if (disp !== 24'h000000) begin failures++; $display("FAIL clr_tick_digits got %h want 000000", disp); end
      checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL clr_tick_wrap got %b want 0", wrap); end
      step(20);
      checks++; if (disp !== 24'h000000) begin failures++; $display("FAIL clr_tick_stays got %h want 000000", disp); end
   endtask

   task automatic test_reset_mid_run();
      do_clear();
      press_start();
      step(19);
      checks++; if (disp !== 24'h000001) begin failures++; $display("FAIL midrst_pre got %h want 000001", disp); end
      resetn = 1'b0;
      step(1);
      checks++; if (disp !== 24'h000000 || running !== 1'b0) begin failures++; $display("FAIL midrst got %h run=%b want 000000 run=0", disp, running); end
      resetn = 1'b1;
      step(15);
      checks++; if (disp !== 24'h000000 || running !== 1'b0) begin failures++; $display("FAIL midrst_after got %h run=%b want 000000 run=0", disp, running); end
   endtask

   initial begin
      test_reset();
      test_start_count();
      test_pause_resume();
      test_lap();
      test_lap_idle();
      test_wrap();
      test_clear_collisions();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
